// File: rtl/pio_config_sequencer.sv
// Autonomous configuration master: streams a program from external memory into the pio,
// then programs wrap, clock divider, pins and enable for one state machine.
module pio_config_sequencer #(
   parameter int HOLD   = 2,
   parameter int NUM_SM = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [5:0]        cfg_plen,
   input  logic [4:0]        cfg_wrap_top,
   input  logic [1:0]        cfg_mindex,
   input  logic [23:0]       cfg_div,
   input  logic [31:0]       cfg_pin_grps,
   input  logic [NUM_SM-1:0] cfg_en_mask,
   output logic [4:0]        prog_addr,
   input  logic [15:0]       prog_data,
   output logic [3:0]        action,
   output logic [4:0]        index,
   output logic [1:0]        mindex,
   output logic [31:0]       din,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   localparam logic [3:0] ACT_NONE  = 4'd0;
   localparam logic [3:0] ACT_INSTR = 4'd1;
   localparam logic [3:0] ACT_WRAP  = 4'd2;
   localparam logic [3:0] ACT_PINS  = 4'd5;
   localparam logic [3:0] ACT_EN    = 4'd6;
   localparam logic [3:0] ACT_DIV   = 4'd7;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_INSTR, S_WRAP, S_DIV, S_PINS, S_EN, S_FIN
   } state_t;

   state_t            state, state_nxt;
   logic [5:0]        idx, idx_nxt, idx_inc;
   logic [HW-1:0]     hold_cnt, hold_nxt;
   logic              hold_last, reject;
   logic [5:0]        plen_q, plen_nxt;
   logic [4:0]        wrap_q, wrap_nxt;
   logic [23:0]       div_q, div_nxt;
   logic [31:0]       pins_q, pins_nxt;
   logic [NUM_SM-1:0] en_q, en_nxt;
   logic [4:0]        prog_addr_nxt, index_nxt;
   logic [3:0]        action_nxt;
   logic [1:0]        mindex_nxt;
   logic [31:0]       din_nxt;
   logic              busy_nxt, done_nxt, err_nxt;

   assign hold_last = (hold_cnt == HW'(HOLD - 1));
   assign idx_inc   = idx + 6'd1;
   assign reject    = (cfg_plen > 6'd32) ||
                      ((cfg_plen != 6'd0) && ({1'b0, cfg_wrap_top} >= cfg_plen));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         hold_cnt  <= '0;
         plen_q    <= '0;
         wrap_q    <= '0;
         div_q     <= '0;
         pins_q    <= '0;
         en_q      <= '0;
         prog_addr <= '0;
         action    <= '0;
         index     <= '0;
         mindex    <= '0;
         din       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         idx       <= idx_nxt;
         hold_cnt  <= hold_nxt;
         plen_q    <= plen_nxt;
         wrap_q    <= wrap_nxt;
         div_q     <= div_nxt;
         pins_q    <= pins_nxt;
         en_q      <= en_nxt;
         prog_addr <= prog_addr_nxt;
         action    <= action_nxt;
         index     <= index_nxt;
         mindex    <= mindex_nxt;
         din       <= din_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         err       <= err_nxt;
      end
   end

   // Outputs are loaded on the edge that enters a state, so they always describe the current state.
   // prog_data is sampled at the end of FETCH, one cycle after prog_addr was presented.
   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      hold_nxt      = hold_cnt;
      plen_nxt      = plen_q;
      wrap_nxt      = wrap_q;
      div_nxt       = div_q;
      pins_nxt      = pins_q;
      en_nxt        = en_q;
      prog_addr_nxt = prog_addr;
      action_nxt    = action;
      index_nxt     = index;
      mindex_nxt    = mindex;
      din_nxt       = din;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      err_nxt       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (reject) begin
                  err_nxt = 1'b1;
               end else begin
                  plen_nxt   = cfg_plen;
                  wrap_nxt   = cfg_wrap_top;
                  div_nxt    = cfg_div;
                  pins_nxt   = cfg_pin_grps;
                  en_nxt     = cfg_en_mask;
                  mindex_nxt = cfg_mindex;
                  busy_nxt   = 1'b1;
                  idx_nxt    = '0;
                  hold_nxt   = '0;
                  if (cfg_plen == 6'd0) begin
                     state_nxt  = S_WRAP;
                     action_nxt = ACT_WRAP;
                     index_nxt  = cfg_wrap_top;
                     din_nxt    = '0;
                  end else begin
                     state_nxt     = S_FETCH;
                     prog_addr_nxt = '0;
                     action_nxt    = ACT_NONE;
                  end
               end
            end
         end
         S_FETCH: begin
            state_nxt  = S_INSTR;
            action_nxt = ACT_INSTR;
            index_nxt  = idx[4:0];
            din_nxt    = {16'h0000, prog_data};
            hold_nxt   = '0;
         end
         S_INSTR: begin
            if (hold_last) begin
               idx_nxt  = idx_inc;
               hold_nxt = '0;
               if (idx_inc < plen_q) begin
                  state_nxt     = S_FETCH;
                  prog_addr_nxt = idx_inc[4:0];
                  action_nxt    = ACT_NONE;
               end else begin
                  state_nxt  = S_WRAP;
                  action_nxt = ACT_WRAP;
                  index_nxt  = wrap_q;
                  din_nxt    = '0;
               end
            end else begin
               hold_nxt = hold_cnt + HW'(1);
            end
         end
         S_WRAP, S_DIV, S_PINS, S_EN: begin
            if (!hold_last) begin
               hold_nxt = hold_cnt + HW'(1);
            end else begin
               hold_nxt = '0;
               case (state)
                  S_WRAP: begin
                     state_nxt  = S_DIV;
                     action_nxt = ACT_DIV;
                     din_nxt    = {8'h00, div_q};
                  end
                  S_DIV: begin
                     state_nxt  = S_PINS;
                     action_nxt = ACT_PINS;
                     din_nxt    = pins_q;
                  end
                  S_PINS: begin
                     state_nxt  = S_EN;
                     action_nxt = ACT_EN;
                     din_nxt    = '0;
                     din_nxt[NUM_SM-1:0] = en_q;
                  end
                  default: begin
                     state_nxt  = S_FIN;
                     action_nxt = ACT_NONE;
                     busy_nxt   = 1'b0;
                     done_nxt   = 1'b1;
                  end
               endcase
            end
         end
         S_FIN: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_pio_config_sequencer.sv
// Bench for pio_config_sequencer: table-driven runs scored against a queue of expected pio
// actions, plus hand sequences for restart, mid-run reset and a full 32-word program at HOLD=1.
module tb_pio_config_sequencer;

   localparam int HOLD_A = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_a, start_b;
   logic [5:0]  cfg_plen;
   logic [4:0]  cfg_wrap_top;
   logic [1:0]  cfg_mindex;
   logic [23:0] cfg_div;
   logic [31:0] cfg_pin_grps;
   logic [3:0]  cfg_en_mask;
   logic [15:0] mem [32];

   logic [4:0]  prog_addr_a, index_a, prog_addr_b, index_b;
   logic [15:0] prog_data_a, prog_data_b;
   logic [3:0]  action_a, action_b;
   logic [1:0]  mindex_a, mindex_b;
   logic [31:0] din_a, din_b;
   logic        busy_a, done_a, err_a, busy_b, done_b, err_b;

   always #5 clk = ~clk;

   assign prog_data_a = mem[prog_addr_a];
   assign prog_data_b = mem[prog_addr_b];

   pio_config_sequencer #(.HOLD(HOLD_A), .NUM_SM(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a),
      .cfg_plen(cfg_plen), .cfg_wrap_top(cfg_wrap_top), .cfg_mindex(cfg_mindex),
      .cfg_div(cfg_div), .cfg_pin_grps(cfg_pin_grps), .cfg_en_mask(cfg_en_mask),
      .prog_addr(prog_addr_a), .prog_data(prog_data_a), .action(action_a),
      .index(index_a), .mindex(mindex_a), .din(din_a),
      .busy(busy_a), .done(done_a), .err(err_a)
   );

   pio_config_sequencer #(.HOLD(1), .NUM_SM(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .cfg_plen(cfg_plen), .cfg_wrap_top(cfg_wrap_top), .cfg_mindex(cfg_mindex),
      .cfg_div(cfg_div), .cfg_pin_grps(cfg_pin_grps), .cfg_en_mask(cfg_en_mask),
      .prog_addr(prog_addr_b), .prog_data(prog_data_b), .action(action_b),
      .index(index_b), .mindex(mindex_b), .din(din_b),
      .busy(busy_b), .done(done_b), .err(err_b)
   );

   typedef struct {
      logic [5:0]  plen;
      logic [4:0]  wrap_top;
      logic [1:0]  mindex;
      logic [23:0] div;
      logic [31:0] pins;
      logic [3:0]  en;
      bit          exp_err;
      int          exp_busy;
   } vec_t;

   typedef struct {
      logic [3:0]  action;
      logic [4:0]  index;
      logic [31:0] din;
   } exp_t;

   exp_t        expq[$];
   exp_t        mon_e;
   vec_t        vecs[6];
   int          checks = 0;
   int          errors = 0;
   int          busy_cnt = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          run_len = 0;
   logic [3:0]  prev_action = 4'd0;
   logic [4:0]  prev_index = 5'd0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic pushExp(input logic [3:0] a, input logic [4:0] i, input logic [31:0] d);
      exp_t e;
      e.action = a;
      e.index  = i;
      e.din    = d;
      expq.push_back(e);
   endtask

   // Each new (action,index) on DUT A is popped from the scoreboard; each finished action must
   // have lasted exactly HOLD cycles.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_action = 4'd0;
         prev_index  = 5'd0;
         run_len     = 0;
      end else begin
         if (busy_a) busy_cnt++;
         if (done_a) done_cnt++;
         if (err_a)  err_cnt++;
         if (action_a != prev_action || (action_a != 4'd0 && index_a != prev_index)) begin
            if (prev_action != 4'd0) checkOutput("hold_len", run_len, HOLD_A);
            if (action_a != 4'd0) begin
               if (expq.size() == 0) begin
                  checkOutput("unexpected_action", {28'h0, action_a}, 32'h0);
               end else begin
                  mon_e = expq.pop_front();
                  checkOutput("action", {28'h0, action_a}, {28'h0, mon_e.action});
                  checkOutput("index", {27'h0, index_a}, {27'h0, mon_e.index});
                  checkOutput("din", din_a, mon_e.din);
               end
            end
            run_len = 1;
         end else begin
            run_len++;
         end
         prev_action = action_a;
         prev_index  = index_a;
      end
   end

   task automatic launch(input vec_t v);
      cfg_plen     = v.plen;
      cfg_wrap_top = v.wrap_top;
      cfg_mindex   = v.mindex;
      cfg_div      = v.div;
      cfg_pin_grps = v.pins;
      cfg_en_mask  = v.en;
      if (!v.exp_err) begin
         for (int k = 0; k < int'(v.plen); k++)
            pushExp(4'd1, 5'(k), {16'h0, mem[k]});
         pushExp(4'd2, v.wrap_top, 32'h0);
         pushExp(4'd7, v.wrap_top, {8'h0, v.div});
         pushExp(4'd5, v.wrap_top, v.pins);
         pushExp(4'd6, v.wrap_top, {28'h0, v.en});
      end
      busy_cnt = 0;
      done_cnt = 0;
      err_cnt  = 0;
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
   endtask

   task automatic waitRun();
      for (int c = 0; c < 300; c++) begin
         @(posedge clk);
         if (done_cnt + err_cnt > 0) break;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic verifyRun(input vec_t v);
      checkOutput("busy_cycles", busy_cnt, v.exp_err ? 0 : v.exp_busy);
      checkOutput("done_pulses", done_cnt, v.exp_err ? 0 : 1);
      checkOutput("err_pulses", err_cnt, v.exp_err ? 1 : 0);
      checkOutput("pending_actions", expq.size(), 0);
      checkOutput("idle_action", {28'h0, action_a}, 32'h0);
      checkOutput("idle_busy", {31'h0, busy_a}, 32'h0);
      if (!v.exp_err) checkOutput("mindex", {30'h0, mindex_a}, {30'h0, v.mindex});
      expq.delete();
   endtask

   task automatic applyStimulus(input vec_t v);
      launch(v);
      waitRun();
      verifyRun(v);
   endtask

   task automatic runHold1();
      int k = 0;
      int nbusy = 0;
      int ndone = 0;
      logic [3:0] prev = 4'd0;
      cfg_plen = 6'd32; cfg_wrap_top = 5'd31; cfg_mindex = 2'd2;
      cfg_div = 24'h0100_80; cfg_pin_grps = 32'h1234_5678; cfg_en_mask = 4'h4;
      @(posedge clk); #1 start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (busy_b) nbusy++;
         if (action_b == 4'd1 && prev != 4'd1) begin
            checkOutput("b_index", {27'h0, index_b}, k);
            if (k < 32) checkOutput("b_din", din_b, {16'h0, mem[k]});
            k++;
         end
         if (action_b == 4'd2 && prev != 4'd2) checkOutput("b_wrap_index", {27'h0, index_b}, 31);
         if (done_b) begin
            ndone++;
            break;
         end
         prev = action_b;
      end
      repeat (3) @(negedge clk);
      checkOutput("b_instr_count", k, 32);
      checkOutput("b_busy_cycles", nbusy, 68);
      checkOutput("b_done", ndone, 1);
      checkOutput("b_idle_action", {28'h0, action_b}, 32'h0);
      checkOutput("b_index_hold", {27'h0, index_b}, 31);
   endtask

   initial begin
      vec_t alt;
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
      cfg_plen = '0; cfg_wrap_top = '0; cfg_mindex = '0;
      cfg_div = '0; cfg_pin_grps = '0; cfg_en_mask = '0;
      for (int k = 0; k < 32; k++) mem[k] = 16'(k * 16'h0101) ^ 16'h5A3C;
      mem[0] = 16'hE081; mem[1] = 16'hE101; mem[2] = 16'hE000; mem[3] = 16'h0001;

      vecs[0] = '{6'd4,  5'd3,  2'd1, 24'h000280, 32'h0000_0001, 4'h1, 1'b0, 20};
      vecs[1] = '{6'd0,  5'd7,  2'd2, 24'h123456, 32'hA5A5_5A5A, 4'hF, 1'b0, 8};
      vecs[2] = '{6'd33, 5'd3,  2'd3, 24'h000100, 32'h0000_00FF, 4'h3, 1'b1, 0};
      vecs[3] = '{6'd4,  5'd4,  2'd3, 24'h000100, 32'h0000_00FF, 4'h3, 1'b1, 0};
      vecs[4] = '{6'd5,  5'd0,  2'd3, 24'hABCDEF, 32'hDEAD_BEEF, 4'h6, 1'b0, 23};
      vecs[5] = '{6'd0,  5'd31, 2'd0, 24'h000001, 32'h8000_0001, 4'h8, 1'b0, 8};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_action", {28'h0, action_a}, 32'h0);
      checkOutput("rst_busy_done_err", {29'h0, busy_a, done_a, err_a}, 32'h0);
      checkOutput("rst_din", din_a, 32'h0);
      checkOutput("rst_addr_index_mindex", {20'h0, prog_addr_a, index_a, mindex_a}, 32'h0);
      rst_n = 1'b1;

      for (int v = 0; v < 6; v++) applyStimulus(vecs[v]);

      // start with different configuration while busy must be ignored
      launch(vecs[0]);
      repeat (5) @(posedge clk);
      #1;
      cfg_plen = 6'd2; cfg_wrap_top = 5'd1; cfg_mindex = 2'd3;
      cfg_div = 24'hFFFFFF; cfg_pin_grps = 32'h0; cfg_en_mask = 4'h0;
      start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      waitRun();
      verifyRun(vecs[0]);

      // reset while the third instruction is on the bus
      alt = vecs[4];
      launch(alt);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (action_a == 4'd1 && index_a == 5'd2) break;
      end
      checkOutput("reach_instr2", {27'h0, index_a}, 32'd2);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      checkOutput("midrst_action", {28'h0, action_a}, 32'h0);
      checkOutput("midrst_busy", {31'h0, busy_a}, 32'h0);
      checkOutput("midrst_din_index", din_a | {27'h0, index_a}, 32'h0);
      expq.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      checkOutput("midrst_no_done", done_cnt, 0);
      applyStimulus(vecs[0]);

      runHold1();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
